// File: rtl/serdesphy_ana_pkg.sv
// Shared definitions for the analog RX deserializer: word width, default sync pattern and the
// aligner state encoding.
package serdesphy_ana_pkg;

   localparam int unsigned WIDTH = 16;
   localparam logic [15:0] DEF_SYNC_WORD = 16'hC3A5;

   typedef enum logic [1:0] {
      StHunt    = 2'b00,
      StVerify  = 2'b01,
      StAligned = 2'b10
   } rx_state_e;

endpackage

// File: rtl/serdesphy_ana_rx_shreg.sv
// Serial input shift register and free-running bit phase counter for the RX deserializer.
// win is the current sr contents with the incoming bit appended (MSB received first).
module serdesphy_ana_rx_shreg
   import serdesphy_ana_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             shift,
   input  logic             serial_data,
   output logic [WIDTH-1:0] win,
   output logic [3:0]       phase_cnt
);

   logic [WIDTH-1:0] sr_q;
   logic [3:0]       phase_q;

   assign win       = {sr_q[WIDTH-2:0], serial_data};
   assign phase_cnt = phase_q;

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         sr_q    <= '0;
         phase_q <= '0;
      end else if (shift) begin
         sr_q    <= win;
         phase_q <= phase_q + 4'd1;
      end
   end

endmodule

// File: rtl/serdesphy_ana_rx_deser.sv
// RX serial-to-parallel converter and word aligner: hunts for the sync word, verifies alignment
// over consecutive sync words, emits framed words and flags loss of alignment on long runs.
module serdesphy_ana_rx_deser
   import serdesphy_ana_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter logic [15:0] SYNC_WORD    = DEF_SYNC_WORD,
   parameter int unsigned VERIFY_COUNT = 4,
   parameter int unsigned LOSS_COUNT   = 4
) (
   input  logic             clk_240m_rx,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cdr_lock,
   input  logic             serial_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             aligned,
   output logic [3:0]       bit_offset,
   output logic             align_err
);

   rx_state_e state_q, state_d;

   logic             shift;
   logic [WIDTH-1:0] win;
   logic [3:0]       phase_cnt;

   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]       match_cnt_q, match_cnt_d;
   logic [2:0]       loss_cnt_q, loss_cnt_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [3:0]       bit_offset_q, bit_offset_d;
   logic             align_err_q, align_err_d;

   logic       is_sync;
   logic       boundary;
   logic       loss_word;
   logic [2:0] match_inc;
   logic [2:0] loss_inc;
   logic       verify_done;
   logic       loss_done;

   assign shift       = enable & cdr_lock;
   assign is_sync     = (win == SYNC_WORD);
   assign boundary    = shift && (bit_cnt_q == 4'd15);
   assign loss_word   = (win == '0) || (win == '1);
   assign match_inc   = match_cnt_q + 3'd1;
   assign loss_inc    = loss_cnt_q + 3'd1;
   assign verify_done = (match_inc == 3'(VERIFY_COUNT));
   assign loss_done   = loss_word && (loss_inc == 3'(LOSS_COUNT));

   serdesphy_ana_rx_shreg u_shreg (
      .clk         (clk_240m_rx),
      .rst_n       (rst_n),
      .enable      (enable),
      .shift       (shift),
      .serial_data (serial_data),
      .win         (win),
      .phase_cnt   (phase_cnt)
   );

   // State register
   always_ff @(posedge clk_240m_rx) begin
      if (!rst_n) begin
         state_q <= StHunt;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; losing enable or lock always drops back to hunting
   always_comb begin
      state_d = state_q;
      if (!enable || !cdr_lock) begin
         state_d = StHunt;
      end else begin
         unique case (state_q)
            StHunt: begin
               if (is_sync) begin
                  state_d = (VERIFY_COUNT == 1) ? StAligned : StVerify;
               end
            end
            StVerify: begin
               if (boundary) begin
                  if (!is_sync) begin
                     state_d = StHunt;
                  end else if (verify_done) begin
                     state_d = StAligned;
                  end
               end
            end
            StAligned: begin
               if (boundary && loss_done) begin
                  state_d = StHunt;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   // Counter and output-register next values
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      match_cnt_d  = match_cnt_q;
      loss_cnt_d   = loss_cnt_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      bit_offset_d = bit_offset_q;
      align_err_d  = 1'b0;
      if (!enable || !cdr_lock) begin
         bit_cnt_d   = '0;
         match_cnt_d = '0;
         loss_cnt_d  = '0;
         // Lock loss is an alignment error, a deliberate disable is not
         align_err_d = enable && (state_q == StAligned);
      end else begin
         bit_cnt_d = bit_cnt_q + 4'd1;
         unique case (state_q)
            StHunt: begin
               if (is_sync) begin
                  bit_cnt_d    = '0;
                  match_cnt_d  = 3'd1;
                  bit_offset_d = phase_cnt + 4'd1;
               end
            end
            StVerify: begin
               if (boundary) begin
                  match_cnt_d = is_sync ? match_inc : 3'd0;
               end
            end
            StAligned: begin
               if (boundary) begin
                  rx_data_d  = win;
                  rx_valid_d = 1'b1;
                  loss_cnt_d = loss_word ? loss_inc : 3'd0;
                  if (loss_done) begin
                     align_err_d = 1'b1;
                     loss_cnt_d  = '0;
                     match_cnt_d = '0;
                  end
               end
            end
            default: begin
               match_cnt_d = '0;
               loss_cnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_240m_rx) begin
      if (!rst_n) begin
         bit_cnt_q    <= '0;
         match_cnt_q  <= '0;
         loss_cnt_q   <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         bit_offset_q <= '0;
         align_err_q  <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         match_cnt_q  <= match_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         bit_offset_q <= bit_offset_d;
         align_err_q  <= align_err_d;
      end
   end

   // Output decode
   always_comb begin
      aligned    = (state_q == StAligned);
      rx_data    = rx_data_q;
      rx_valid   = rx_valid_q;
      bit_offset = bit_offset_q;
      align_err  = align_err_q;
   end

endmodule

// File: doc/serdesphy_ana_rx_deser.md
# serdesphy_ana_rx_deser

Receive-side serial-to-parallel converter and word aligner that sits directly downstream of the CDR in the analog RX path. It consumes the retimed serial bit on the 240 MHz recovered clock, qualified by the CDR lock indicator. It hunts for a training sync word, verifies alignment over consecutive sync words, and then emits framed parallel words to the digital PCS. It monitors run-length violations to declare loss of alignment.

## Interface
Parameters:
- `WIDTH`, 16: parallel word width; fixed at 16 for this PHY.
- `SYNC_WORD`, 16'hC3A5: training sync pattern, MSB received first.
- `VERIFY_COUNT`, 4: consecutive sync words, including the hunt match, required to declare alignment; range 1..7.
- `LOSS_COUNT`, 4: consecutive all-0 or all-1 words that declare loss of alignment; range 1..7.

Ports:
- `clk_240m_rx` input 1: 240 MHz recovered clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `enable` input 1: block enable.
- `cdr_lock` input 1: CDR lock indicator; bits are shifted only while high.
- `serial_data` input 1: retimed serial bit.
- `rx_data` output 16: aligned parallel word.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is valid on that cycle.
- `aligned` output 1: alignment achieved.
- `bit_offset` output 4: bit phase of the word boundary, latched at hunt match.
- `align_err` output 1: one-cycle pulse on loss of alignment.

## Operation
- Shift qualifier: `shift = enable & cdr_lock`.
- Window: `win = {sr[14:0], serial_data}`. On a shift cycle, `sr <= win`.
- Free-running phase counter `phase_cnt` (4 bits):
  - Increments modulo 16 on every shift.
  - Cleared by reset or by `enable` low.
- Word counter `bit_cnt` (4 bits): a boundary occurs on a shift cycle with `bit_cnt == 15`; the counter then wraps to 0.
- States: HUNT=2'b00, VERIFY=2'b01, ALIGNED=2'b10.
- HUNT:
  - Compares `win` against `SYNC_WORD` on every shift cycle.
  - On a match: `bit_cnt <= 0`, `match_cnt <= 1`, `bit_offset <= (phase_cnt+1) mod 16`.
  - After a match, the next state is VERIFY, or ALIGNED if `VERIFY_COUNT == 1`.
- VERIFY, at each boundary:
  - If `win == SYNC_WORD`, increment `match_cnt`. When `match_cnt` reaches `VERIFY_COUNT`, go to ALIGNED.
  - Any mismatch returns to HUNT with `match_cnt <= 0`. No `align_err` is raised.
- ALIGNED, at each boundary:
  - `rx_data <= win`, `rx_valid <= 1`.
  - If `win` is 16'h0000 or 16'hFFFF, increment `loss_cnt`; any other word clears it.
  - When `loss_cnt` reaches `LOSS_COUNT`: go to HUNT, `align_err <= 1`, `aligned <= 0`. The violating word is still emitted.
- Sync words received while ALIGNED are emitted as data.
- `aligned` is 1 exactly while state == ALIGNED.
- `rx_valid` is asserted only for boundaries processed in ALIGNED. It is never asserted in HUNT or VERIFY.
- `cdr_lock` low with `enable` high:
  - No shift occurs.
  - State goes to HUNT; `match_cnt`, `loss_cnt` and `bit_cnt` are cleared; any partial word is discarded.
  - If the state was ALIGNED, `align_err` pulses.
- `enable` low:
  - Same as `cdr_lock` low, plus `phase_cnt` and `sr` are cleared.
  - `align_err` is never raised.
- Priority: `rst_n` > `enable` > `cdr_lock` > state logic.
- Reset values:
  - `sr`, `rx_data`, `bit_offset`: 0.
  - `rx_valid`, `aligned`, `align_err`: 0.
  - State: HUNT.
  - `match_cnt`, `loss_cnt`, `bit_cnt`, `phase_cnt`: 0.
- `rx_data` and `bit_offset` hold their last values when not updated.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: the last bit of a word sampled at cycle N gives `rx_valid`/`rx_data` at cycle N+1.
- `aligned` rises at N+1 after the boundary that completes verification. The first `rx_valid` follows 16 shift cycles later.
- `align_err` is high for exactly one cycle. It fires at N+1 after the violating boundary, or one cycle after `cdr_lock` falls.
- Reset asserted mid-word: all state is cleared at the next clock edge, and no `rx_valid` is produced for the partial word.
- Words are back-to-back with no gaps: `rx_valid` recurs every 16 cycles while `cdr_lock` stays high.

## Structure
- Shared package `serdesphy_ana_pkg`:
  - State encodings HUNT/VERIFY/ALIGNED.
  - Default `SYNC_WORD`.
  - `WIDTH`.
- Sub-module `serdesphy_ana_rx_shreg` (shift register plus `phase_cnt`) is natural; the FSM, counters and output registers stay in the top.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random `serial_data` → all outputs 0 and state HUNT.
- Bits 3'b101, then 4× 16'hC3A5, then 16'h1234 → `aligned`=1 one cycle after the 4th sync; a single `rx_valid` with `rx_data`=16'h1234; `bit_offset`=3.
- Sync, sync, then 16'h0001 → state back to HUNT; `aligned` never rises; no `rx_valid`; `align_err`=0.
- When aligned, send 4× 16'h0000 → 4 `rx_valid` strobes, then `align_err` pulses and `aligned`=0. Separately, send 3× 16'hFFFF then 16'h5555 → stays aligned.
- When aligned, drop `cdr_lock` 7 bits into a word → next cycle `aligned`=0 and `align_err`=1 for one cycle, with no partial word. Restore lock and resend syncs → realigns.
- When aligned, drop `enable` → `aligned`=0 with no `align_err`; `phase_cnt` cleared, checked via `bit_offset` on re-hunt.
